// File: rtl/pwm_dt_pkg.sv
// +------------------------------------------------------------------+
// | pwm_dt_pkg : shared state encoding and defaults for dead-time gen |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pwm_dt_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_SAFE  = 3'd0,
    ST_LS_ON = 3'd1,
    ST_DT_R  = 3'd2,
    ST_HS_ON = 3'd3,
    ST_DT_F  = 3'd4
  } ch_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_dt_channel.sv
// +------------------------------------------------------------------+
// | pwm_dt_channel : one half-bridge FSM with dead-time down-counter  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pwm_dt_channel
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_force_safe,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  output logic            o_hs,
  output logic            o_ls
);

  localparam logic [DT_W-1:0] c_one = DT_W'(1);

  ch_state_e       r_state;
  ch_state_e       w_state_nxt;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cnt_nxt;
  logic [DT_W-1:0] w_rise_load;
  logic [DT_W-1:0] w_fall_load;

  // Load value is max(dt,1)-1, so a zero setting still yields one off cycle.
  assign w_rise_load = (i_dt_rise == '0) ? '0 : i_dt_rise - c_one;
  assign w_fall_load = (i_dt_fall == '0) ? '0 : i_dt_fall - c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_force_safe) begin
      w_state_nxt = ST_SAFE;
    end else begin
      case (r_state)
        ST_SAFE, ST_LS_ON: begin
          if (i_pwm) begin
            w_state_nxt = ST_DT_R;
            w_cnt_nxt   = w_rise_load;
          end else begin
            w_state_nxt = ST_LS_ON;
          end
        end
        ST_DT_R: begin
          if (!i_pwm)            w_state_nxt = ST_LS_ON;
          else if (r_cnt == '0)  w_state_nxt = ST_HS_ON;
          else                   w_cnt_nxt   = r_cnt - c_one;
        end
        ST_HS_ON: begin
          if (!i_pwm) begin
            w_state_nxt = ST_DT_F;
            w_cnt_nxt   = w_fall_load;
          end
        end
        ST_DT_F: begin
          if (i_pwm)             w_state_nxt = ST_HS_ON;
          else if (r_cnt == '0)  w_state_nxt = ST_LS_ON;
          else                   w_cnt_nxt   = r_cnt - c_one;
        end
        default: w_state_nxt = ST_SAFE;
      endcase
    end
  end

  // Gate drives are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SAFE;
      r_cnt   <= '0;
      o_hs    <= 1'b0;
      o_ls    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_hs    <= (w_state_nxt == ST_HS_ON);
      o_ls    <= (w_state_nxt == ST_LS_ON);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_deadtime_gen.sv
// +------------------------------------------------------------------+
// | pwm_deadtime_gen : complementary gate drives with dead time/fault |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DT_W = DT_W_DEF
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_pwm,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  input  logic            i_fault,
  input  logic            i_fault_clr,
  output logic [N_CH-1:0] o_hs,
  output logic [N_CH-1:0] o_ls,
  output logic            o_fault
);

  logic [N_CH-1:0] r_pwm_q;
  logic            r_fault;
  logic            w_force_safe;

  // Channels stay SAFE through the edge that clears the latch and resume after.
  assign w_force_safe = i_fault | r_fault | ~i_en;
  assign o_fault      = r_fault;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_pwm_q <= '0;
      r_fault <= 1'b0;
    end else begin
      r_pwm_q <= i_pwm;
      if (i_fault)          r_fault <= 1'b1;
      else if (i_fault_clr) r_fault <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pwm_dt_channel #(
        .DT_W (DT_W)
      ) u_ch (
        .clk          (CLK_I),
        .rst          (RST_I),
        .i_force_safe (w_force_safe),
        .i_pwm        (r_pwm_q[g]),
        .i_dt_rise    (i_dt_rise),
        .i_dt_fall    (i_dt_fall),
        .o_hs         (o_hs[g]),
        .o_ls         (o_ls[g])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_deadtime_gen.sv
// +------------------------------------------------------------------+
// | tb_pwm_deadtime_gen : directed self-checking bench                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pwm_deadtime_gen;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] pwm;
  logic [7:0]   dt_rise;
  logic [7:0]   dt_fall;
  logic         fault;
  logic         fault_clr;
  logic [N-1:0] hs;
  logic [N-1:0] ls;
  logic         fault_o;

  int n_pass  = 0;
  int n_total = 0;

  int hs_run[N], ls_run[N], gap[N];
  int last_hs[N], last_ls[N], gap_hs[N], gap_ls[N];

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.N_CH(N), .DT_W(8)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .i_en        (en),
    .i_pwm       (pwm),
    .i_dt_rise   (dt_rise),
    .i_dt_fall   (dt_fall),
    .i_fault     (fault),
    .i_fault_clr (fault_clr),
    .o_hs        (hs),
    .o_ls        (ls),
    .o_fault     (fault_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // One clock step: sample 1 time unit after the edge, check the overlap
  // invariant, and update per-channel run-length trackers.
  task automatic tick();
    @(posedge clk);
    #1;
    check("hs_ls_overlap", int'(hs & ls), 0);
    for (int c = 0; c < N; c++) begin
      if (hs[c]) hs_run[c]++;
      else if (hs_run[c] > 0) begin last_hs[c] = hs_run[c]; hs_run[c] = 0; end
      if (ls[c]) ls_run[c]++;
      else if (ls_run[c] > 0) begin last_ls[c] = ls_run[c]; ls_run[c] = 0; end
      if (!hs[c] && !ls[c]) gap[c]++;
      else begin
        if (gap[c] > 0) begin
          if (hs[c]) gap_hs[c] = gap[c];
          else       gap_ls[c] = gap[c];
        end
        gap[c] = 0;
      end
    end
  endtask

  task automatic run_square(input int periods, input int half);
    for (int p = 0; p < periods; p++) begin
      pwm = '1;
      repeat (half) tick();
      pwm = '0;
      repeat (half) tick();
    end
  endtask

  initial begin
    int lowc;
    int hs_seen;
    int hi[N];

    for (int c = 0; c < N; c++) begin
      hs_run[c] = 0; ls_run[c] = 0; gap[c] = 0;
      last_hs[c] = 0; last_ls[c] = 0; gap_hs[c] = 0; gap_ls[c] = 0;
    end

    // 1: reset state and first low-side turn-on
    rst = 1'b1; en = 1'b1; pwm = '0; dt_rise = 8'd3; dt_fall = 8'd5;
    fault = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hs", int'(hs), 0);
    check("rst_ls", int'(ls), 0);
    check("rst_fault", int'(fault_o), 0);
    rst = 1'b0;
    tick();
    tick();
    check("start_ls", int'(ls), 15);
    check("start_hs", int'(hs), 0);

    // 2: 40-cycle period, 50% duty, dt 3/5
    run_square(3, 20);
    for (int c = 0; c < N; c++) begin
      check("t2_hs_width", last_hs[c], 17);
      check("t2_ls_width", last_ls[c], 15);
      check("t2_gap_hs", gap_hs[c], 3);
      check("t2_gap_ls", gap_ls[c], 5);
    end

    // 3: zero dead time still gives one off cycle
    dt_rise = 8'd0; dt_fall = 8'd0;
    run_square(3, 20);
    check("t3_hs_width", last_hs[0], 19);
    check("t3_ls_width", last_ls[0], 19);
    check("t3_gap_hs", gap_hs[0], 1);
    check("t3_gap_ls", gap_ls[0], 1);

    // 3b: one-cycle pulse shorter than dead time is absorbed
    dt_rise = 8'd4;
    lowc = 0; hs_seen = 0;
    pwm = '1;
    tick();
    pwm = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ls[0]) lowc++;
      if (hs[0])  hs_seen = 1;
    end
    check("t3_short_hs", hs_seen, 0);
    check("t3_short_ls_low", lowc, 1);

    // 6: independent channels, 25%/50% duty with phase offsets
    dt_rise = 8'd2; dt_fall = 8'd2;
    hi[0] = 10; hi[1] = 20; hi[2] = 10; hi[3] = 20;
    for (int t = 0; t < 160; t++) begin
      for (int c = 0; c < N; c++) pwm[c] = (((t + 5 * c) % 40) < hi[c]);
      tick();
    end
    check("t6_hs_ch0", last_hs[0], 8);
    check("t6_hs_ch1", last_hs[1], 18);
    check("t6_hs_ch2", last_hs[2], 8);
    check("t6_hs_ch3", last_hs[3], 18);
    check("t6_ls_ch0", last_ls[0], 28);
    check("t6_ls_ch1", last_ls[1], 18);

    // 4: fault while in HS_ON
    dt_rise = 8'd3; dt_fall = 8'd5;
    pwm = '1;
    repeat (10) tick();
    check("t4_hs_on", int'(hs), 15);
    fault = 1'b1;
    tick();
    check("t4_fault_hs", int'(hs), 0);
    check("t4_fault_ls", int'(ls), 0);
    check("t4_fault_set", int'(fault_o), 1);
    fault = 1'b0;
    tick();
    check("t4_fault_hold", int'(fault_o), 1);
    check("t4_hold_hs", int'(hs), 0);
    fault = 1'b1; fault_clr = 1'b1;
    tick();
    check("t4_fault_wins", int'(fault_o), 1);
    fault = 1'b0; fault_clr = 1'b0;
    tick();
    check("t4_still_set", int'(fault_o), 1);
    fault_clr = 1'b1;
    tick();
    check("t4_cleared", int'(fault_o), 0);
    check("t4_clr_hs", int'(hs), 0);
    fault_clr = 1'b0;
    repeat (3) tick();
    check("t4_resume_dt", int'(hs), 0);
    tick();
    check("t4_resume_hs", int'(hs), 15);

    // 5: enable dropped mid dead time, then async reset mid HS_ON
    pwm = '0;
    tick();
    tick();
    tick();
    check("t5_in_dt", int'(hs | ls), 0);
    en = 1'b0;
    tick();
    check("t5_en_off_hs", int'(hs), 0);
    check("t5_en_off_ls", int'(ls), 0);
    en = 1'b1;
    tick();
    check("t5_en_on_ls", int'(ls), 15);
    pwm = '1;
    repeat (10) tick();
    check("t5_pre_rst_hs", int'(hs), 15);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_hs", int'(hs), 0);
    check("t5_async_ls", int'(ls), 0);
    check("t5_async_fault", int'(fault_o), 0);
    #3;
    rst = 1'b0;
    pwm = '0;
    tick();
    tick();
    check("t5_post_rst_ls", int'(ls), 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
